src_byte_reader: RTL and testbench
==================================

SRC_BYTE_READER -- requirements
Module: src_byte_reader

Interface
REQ-001 SHALL have parameter LZF_WIDTH, default 20: width of byte-count ports.
REQ-002 SHALL have ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- src_empty  input  1  source FIFO has no readable word.
- fi  input  64  source word; byte 0 = fi[7:0], byte 7 = fi[63:56].
- m_last  input  1  terminator flag returned with fi.
- fi_cnt  input  LZF_WIDTH  total payload bytes; sampled in IDLE.
- m_src_getn  output  1  active-low read strobe to source FIFO.
- bo  output  8  byte to encoder core.
- bo_valid  output  1  bo holds a valid byte.
- bo_ready  input  1  core accepts bo this cycle.
- bo_last  output  1  marks final payload byte.
- m_endn  output  1  active-low end-of-stream indication.
- bo_cnt  output  LZF_WIDTH  bytes transferred so far.

Function
REQ-003 SHALL drive m_src_getn low for exactly one cycle per word read, only when src_empty==0 in that cycle.
REQ-004 SHALL sample fi and m_last on the rising edge one cycle after the edge that sampled m_src_getn==0 (read latency 1).
REQ-005 SHALL implement FSM IDLE -> REQ -> WAIT -> SHIFT -> (REQ | DONE); DONE -> IDLE only on rst.
REQ-006 IDLE: SHALL latch fi_cnt, clear bo_cnt, and enter REQ on the next cycle.
REQ-007 REQ: SHALL assert m_src_getn=0 when src_empty==0 and enter WAIT; otherwise hold with m_src_getn=1.
REQ-008 WAIT: SHALL capture the word. m_last==1 enters DONE with the word discarded. m_last==0 enters SHIFT with byte index 0.
REQ-009 SHIFT: SHALL present byte[index] on bo with bo_valid=1 while bo_cnt < latched fi_cnt.
REQ-010 SHALL transfer a byte when bo_valid && bo_ready; bo_cnt increments by 1 and index increments by 1. bo and bo_valid SHALL stay stable while bo_ready==0.
REQ-011 SHALL assert bo_last with bo_valid when bo_cnt == fi_cnt-1.
REQ-012 After index 7 transfers, or once bo_cnt reaches fi_cnt, SHALL leave SHIFT for REQ. Remaining bytes of that word SHALL be dropped unsent (padding).
REQ-013 Once bo_cnt == fi_cnt, SHALL keep bo_valid=0 and keep reading and discarding words until the m_last word arrives.
REQ-014 DONE: SHALL drive m_endn=0, bo_valid=0, m_src_getn=1, and hold.
REQ-015 fi_cnt==0: SHALL emit no bytes, never assert bo_last, and enter DONE on the m_last word.
REQ-016 bo_cnt SHALL be LZF_WIDTH bits. Comparisons SHALL use the latched fi_cnt, so changes to fi_cnt after IDLE have no effect.
REQ-017 An m_last word arriving before fi_cnt bytes are sent SHALL enter DONE immediately. bo_last is then never asserted.

Reset
REQ-018 rst=1 SHALL force IDLE in the same cycle: m_src_getn=1, bo_valid=0, bo_last=0, m_endn=1, bo=0, bo_cnt=0, index=0. Mid-word data is discarded.
REQ-019 rst SHALL override all other inputs, including a simultaneous bo_ready or a returning read.

Configuration
REQ-020 Macro LZS_RDR_PREFETCH_EN defined: SHALL add a one-word prefetch register and issue the next read during SHIFT, from index 5 onward, when src_empty==0. With a continuously ready core and a non-empty source, SHALL sustain one byte per cycle with no bubble between words.
REQ-021 Macro LZS_RDR_PREFETCH_EN undefined: SHALL read strictly as in REQ-005..012. This leaves a minimum 2-cycle bo_valid gap between words. The prefetch register and its logic SHALL be absent.
REQ-022 Both builds SHALL produce identical byte sequences, bo_last placement, and m_endn behaviour.

Verification
REQ-023 Bench SHALL cover these scenarios:
- fi_cnt=16, words 0x0706050403020100 and 0x0F0E0D0C0B0A0908, then m_last word; bo_ready=1 -> bytes 0x00..0x0F in order; bo_last with 0x0F; bo_cnt=16; m_endn=0 after the terminator.
- fi_cnt=13, two data words -> 13 bytes sent; bytes 13..15 dropped; bo_last on byte 12.
- fi_cnt=8, bo_ready toggles every cycle, src_empty=1 for 20 cycles before each word -> bo stable while not ready; m_src_getn never low while src_empty=1; 8 bytes correct.
- fi_cnt=0, terminator word only -> bo_valid never 1; m_endn=0 two cycles after the read strobe.
- rst pulsed during SHIFT at byte 3 -> next cycle all outputs at reset values; a fresh 8-byte stream then completes correctly.
- Prefetch build, fi_cnt=32, 4 words, source never empty, bo_ready=1 -> 32 consecutive bo_valid cycles; non-prefetch build shows 2-cycle gaps; byte streams identical.

Source files
------------

// File: rtl/src_byte_reader.sv
// Byte serializer between a 64-bit source FIFO and the encoder core.
// Optional macro LZS_RDR_PREFETCH_EN adds a one-word prefetch for gapless output.
module src_byte_reader #(
  parameter int LZF_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_empty,
  input  logic [63:0]          fi,
  input  logic                 m_last,
  input  logic [LZF_WIDTH-1:0] fi_cnt,
  output logic                 m_src_getn,
  output logic [7:0]           bo,
  output logic                 bo_valid,
  input  logic                 bo_ready,
  output logic                 bo_last,
  output logic                 m_endn,
  output logic [LZF_WIDTH-1:0] bo_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t               state, nxt_state;
  logic [63:0]          word_q;
  logic [2:0]           idx;
  logic [LZF_WIDTH-1:0] cnt_q;
  logic                 more, xfer, word_end;

  assign more = bo_cnt < cnt_q;
  assign xfer = bo_valid && bo_ready;
  // A word is finished after its last byte, after the final payload byte,
  // or immediately once the payload is complete (the word is then padding).
  assign word_end = (state == S_SHIFT) &&
                    (!more || (xfer && (idx == 3'd7 || bo_cnt + LZF_WIDTH'(1) == cnt_q)));

`ifdef LZS_RDR_PREFETCH_EN
  logic        pf_rd, pf_pend, pf_vld, pf_last, take_next;
  logic [63:0] pf_word;

  assign pf_rd     = (state == S_SHIFT) && (idx >= 3'd5) && !src_empty && !pf_pend && !pf_vld;
  // Data returning this edge can be used directly instead of parking it first.
  assign take_next = word_end && (pf_vld || pf_pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      pf_pend <= 1'b0;
      pf_vld  <= 1'b0;
      pf_last <= 1'b0;
      pf_word <= '0;
    end else begin
      pf_pend <= pf_rd && !word_end;
      if (take_next) begin
        pf_vld <= 1'b0;
      end else if (pf_pend) begin
        pf_vld  <= 1'b1;
        pf_word <= fi;
        pf_last <= m_last;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:  nxt_state = S_REQ;
      S_REQ:   if (!src_empty) nxt_state = S_WAIT;
      S_WAIT:  nxt_state = m_last ? S_DONE : S_SHIFT;
      S_SHIFT: begin
        if (word_end) begin
`ifdef LZS_RDR_PREFETCH_EN
          if (take_next)  nxt_state = (pf_vld ? pf_last : m_last) ? S_DONE : S_SHIFT;
          else if (pf_rd) nxt_state = S_WAIT;
          else            nxt_state = S_REQ;
`else
          nxt_state = S_REQ;
`endif
        end
      end
      S_DONE:  nxt_state = S_DONE;
      default: nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    m_src_getn = 1'b1;
    bo_valid   = (state == S_SHIFT) && more;
    bo_last    = bo_valid && (bo_cnt == cnt_q - LZF_WIDTH'(1));
    bo         = bo_valid ? word_q[{idx, 3'b000} +: 8] : 8'h00;
    m_endn     = (state != S_DONE);
    case (state)
      S_REQ:   m_src_getn = src_empty;
      S_SHIFT: begin
`ifdef LZS_RDR_PREFETCH_EN
        m_src_getn = !pf_rd;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      bo_cnt <= '0;
      idx    <= 3'd0;
      word_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_q  <= fi_cnt;
          bo_cnt <= '0;
          idx    <= 3'd0;
        end
        S_WAIT: begin
          word_q <= fi;
          idx    <= 3'd0;
        end
        S_SHIFT: begin
          if (xfer) begin
            bo_cnt <= bo_cnt + LZF_WIDTH'(1);
            idx    <= idx + 3'd1;
          end
`ifdef LZS_RDR_PREFETCH_EN
          if (take_next) begin
            word_q <= pf_vld ? pf_word : fi;
            idx    <= 3'd0;
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_src_byte_reader.sv
// Bench for src_byte_reader: scenario table, source FIFO model and byte scoreboard.
module tb_src_byte_reader;
  localparam int W = 20;
`ifdef LZS_RDR_PREFETCH_EN
  localparam int SPAN32 = 32;
`else
  localparam int SPAN32 = 38;
`endif

  logic         clk = 1'b0, rst = 1'b1, src_empty = 1'b1, m_last = 1'b0, bo_ready = 1'b0;
  logic [63:0]  fi = '0;
  logic [W-1:0] fi_cnt = '0;
  logic         m_src_getn, bo_valid, bo_last, m_endn;
  logic [7:0]   bo;
  logic [W-1:0] bo_cnt;

  always #5 clk = ~clk;

  src_byte_reader #(.LZF_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .src_empty(src_empty), .fi(fi), .m_last(m_last),
    .fi_cnt(fi_cnt), .m_src_getn(m_src_getn), .bo(bo), .bo_valid(bo_valid),
    .bo_ready(bo_ready), .bo_last(bo_last), .m_endn(m_endn), .bo_cnt(bo_cnt)
  );

  typedef struct {
    int fi_cnt; int nwords; int rmode; int gap; int base;
    int exp_n; bit exp_last; int exp_span;
  } scn_t;

  scn_t       tbl[7];
  logic [64:0] src_q[$];
  logic [8:0]  exp_q[$];
  int  n_tests = 0, n_fail = 0;
  int  gap_cfg = 0, gap_left = 0, rmode = 0, cyc = 0;
  bit  rd_seen = 0, saw_last = 0, prev_hold = 0, prev_rst = 1;
  logic [7:0] prev_bo = '0;
  int  first_x, last_x, n_x, rd_cyc, endn_cyc, getn_err, last_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: sample everything mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [8:0] e;
    cyc++;
    rd_seen = !m_src_getn && !rst;
    if (!m_src_getn && src_empty) getn_err++;
    if (rd_seen) rd_cyc = cyc;
    if (!m_endn && endn_cyc < 0) endn_cyc = cyc;
    if (bo_last && !bo_valid) last_err++;
    if (prev_hold && !prev_rst) begin
      chk("hold_valid", bo_valid, 1'b1);
      chk("hold_bo", bo, prev_bo);
    end
    if (bo_valid && bo_ready && !rst) begin
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
      n_x++;
      if (bo_last) saw_last = 1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_byte: got byte %0h, want no byte", bo);
      end else begin
        e = exp_q.pop_front();
        chk("bo", bo, e[7:0]);
        chk("bo_last", bo_last, e[8]);
      end
    end
    prev_hold = bo_valid && !bo_ready;
    prev_bo   = bo;
    prev_rst  = rst;
  end

  // Source FIFO model (read latency 1) and bo_ready pattern.
  always @(posedge clk) begin
    logic [64:0] w;
    #1;
    if (rd_seen) begin
      if (src_q.size() > 0) begin
        w = src_q.pop_front();
        fi = w[63:0];
        m_last = w[64];
      end
      gap_left = gap_cfg;
    end else if (gap_left > 0) begin
      gap_left--;
    end
    src_empty = (src_q.size() == 0) || (gap_left > 0);
    case (rmode)
      0:       bo_ready = 1'b1;
      1:       bo_ready = !bo_ready;
      default: bo_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic clear_stats();
    first_x = -1; last_x = -1; n_x = 0; rd_cyc = -1; endn_cyc = -1;
    getn_err = 0; last_err = 0; saw_last = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_getn"},   m_src_getn, 1'b1);
    chk({tag, "_valid"},  bo_valid,   1'b0);
    chk({tag, "_last"},   bo_last,    1'b0);
    chk({tag, "_endn"},   m_endn,     1'b1);
    chk({tag, "_bo"},     bo,         8'h00);
    chk({tag, "_bo_cnt"}, bo_cnt,     '0);
  endtask

  task automatic load(input scn_t s);
    logic [63:0] w;
    @(negedge clk); #2;
    rst = 1'b1;
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < s.nwords; i++) begin
      for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(s.base + 8*i + k);
      src_q.push_back({1'b0, w});
    end
    src_q.push_back({1'b1, 64'hDEAD_BEEF_0BAD_F00D});
    for (int j = 0; j < s.exp_n; j++)
      exp_q.push_back({(j == s.exp_n - 1) && s.exp_last, 8'(s.base + j)});
    fi_cnt = W'(s.fi_cnt);
    rmode = s.rmode;
    gap_cfg = s.gap;
    gap_left = s.gap;
    repeat (2) @(negedge clk);
    #2;
    clear_stats();
    chk_reset_outs("rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    fi_cnt = W'($urandom);
  endtask

  task automatic finish_run(input scn_t s);
    for (int c = 0; c < 3000 && m_endn; c++) @(negedge clk);
    #2;
    if (m_endn) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: m_endn still 1, want 0 within 3000 cycles");
    end
    repeat (3) @(negedge clk);
    #2;
    chk("bytes_left", exp_q.size(), 0);
    chk("bo_cnt_end", bo_cnt, s.exp_n);
    chk("saw_last", saw_last, s.exp_last);
    chk("n_xfer", n_x, s.exp_n);
    chk("getn_while_empty", getn_err, 0);
    chk("last_wo_valid", last_err, 0);
    chk("words_left", src_q.size(), 0);
    chk("done_endn", m_endn, 1'b0);
    chk("done_valid", bo_valid, 1'b0);
    chk("done_getn", m_src_getn, 1'b1);
    if (s.fi_cnt == 0) chk("endn_after_strobe", endn_cyc - rd_cyc, 2);
    if (s.exp_span > 0) chk("valid_span", last_x - first_x + 1, s.exp_span);
  endtask

  initial begin
    scn_t rs;
    //          cnt nw mode gap base  n  last span
    tbl[0] = '{16, 2, 0,  0, 8'h00, 16, 1, 0};
    tbl[1] = '{13, 2, 0,  0, 8'h40, 13, 1, 0};
    tbl[2] = '{ 8, 1, 1, 20, 8'h90,  8, 1, 0};
    tbl[3] = '{ 0, 0, 0,  0, 8'h00,  0, 0, 0};
    tbl[4] = '{32, 4, 0,  0, 8'h20, 32, 1, SPAN32};
    tbl[5] = '{20, 2, 2,  3, 8'hC0, 16, 0, 0};
    tbl[6] = '{ 5, 3, 2,  1, 8'h11,  5, 1, 0};

    for (int t = 0; t < 7; t++) begin
      load(tbl[t]);
      finish_run(tbl[t]);
    end

    // Reset while the fourth byte of a word is on bo, then a fresh stream.
    rs = '{16, 2, 0, 0, 8'h50, 16, 1, 0};
    load(rs);
    begin
      int c;
      for (c = 0; c < 200 && !(bo_valid && bo_cnt == W'(3)); c++) @(negedge clk);
      #2;
      chk("reached_byte3", bo_cnt, 3);
    end
    rst = 1'b1;
    @(negedge clk); #2;
    chk_reset_outs("midrst");
    rs = '{8, 1, 0, 0, 8'hA0, 8, 1, 0};
    load(rs);
    finish_run(rs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
